// File: rtl/laplacian_pkg.sv
// Shared types and constants for the Laplacian window controller.
package laplacian_pkg;

  localparam int unsigned DEF_IMG_W = 64;
  localparam int unsigned DEF_IMG_H = 64;
  localparam int unsigned DEF_PIX_W = 8;

  // Number of taps in the 3x3 window
  localparam int unsigned WIN_N = 9;

  // Window tap indices, row-major from top-left
  localparam logic [3:0] P_TL = 4'd0;
  localparam logic [3:0] P_TM = 4'd1;
  localparam logic [3:0] P_TR = 4'd2;
  localparam logic [3:0] P_ML = 4'd3;
  localparam logic [3:0] P_C  = 4'd4;
  localparam logic [3:0] P_MR = 4'd5;
  localparam logic [3:0] P_BL = 4'd6;
  localparam logic [3:0] P_BM = 4'd7;
  localparam logic [3:0] P_BR = 4'd8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_e;

endpackage

// File: rtl/lap_line_buffer.sv
// Single-port line buffer: combinational read of the old word, synchronous write.
module lap_line_buffer #(
  parameter  int unsigned DEPTH = 64,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read returns the word before this cycle's write lands
  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/laplacian_window_ctrl.sv
// Raster-scan 3x3 window sequencer feeding the Laplacian kernel.
module laplacian_window_ctrl
  import laplacian_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H,
  parameter int unsigned PIX_W = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
  output logic [PIX_W-1:0] p4,
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic [PIX_W-1:0] p8,
  output logic [PIX_W-1:0] p9,
  output logic             out_last,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  state_e state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [WIN_N-1:0][PIX_W-1:0] win_q, win_d;
  logic out_valid_q, out_valid_d;
  logic out_last_q, out_last_d;
  logic frame_done_q, frame_done_d;
  logic busy_q, busy_d;

  logic             accept;
  logic             last_pix;
  logic             emit;
  logic             last_taken;
  logic [PIX_W-1:0] lb0_rdata;
  logic [PIX_W-1:0] lb1_rdata;

  // Handshake and position qualifiers
  always_comb begin
    in_ready   = (state_q == ACTIVE) && (!out_valid_q || out_ready);
    accept     = in_valid && in_ready;
    last_pix   = (row_q == ROW_MAX) && (col_q == COL_MAX);
    emit       = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    last_taken = out_valid_q && out_ready && out_last_q;
  end

  // lb0 holds row r-1; lb1 holds row r-2 (fed from lb0's old word)
  lap_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb0 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (in_pixel),
    .rdata_o (lb0_rdata)
  );

  lap_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb1 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (lb0_rdata),
    .rdata_o (lb1_rdata)
  );

  // Frame sequencing: next state and frame_done pulse
  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (accept && last_pix) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (last_taken) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Raster position counters
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (state_q == IDLE && start) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Window shift: left one column, new right column from buffers and input
  always_comb begin
    win_d = win_q;
    if (accept) begin
      win_d[P_TL] = win_q[P_TM];
      win_d[P_TM] = win_q[P_TR];
      win_d[P_TR] = lb1_rdata;
      win_d[P_ML] = win_q[P_C];
      win_d[P_C]  = win_q[P_MR];
      win_d[P_MR] = lb0_rdata;
      win_d[P_BL] = win_q[P_BM];
      win_d[P_BM] = win_q[P_BR];
      win_d[P_BR] = in_pixel;
    end
  end

  // Output valid/last: load on emit, clear on acceptance, hold on stall
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (emit) begin
      out_valid_d = 1'b1;
      out_last_d  = last_pix;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // State register and all output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign p1 = win_q[P_TL];
  assign p2 = win_q[P_TM];
  assign p3 = win_q[P_TR];
  assign p4 = win_q[P_ML];
  assign p5 = win_q[P_C];
  assign p6 = win_q[P_MR];
  assign p7 = win_q[P_BL];
  assign p8 = win_q[P_BM];
  assign p9 = win_q[P_BR];

endmodule

// File: tb/tb_laplacian_window_ctrl.sv
// Directed bench: 4x4 instance (A) and 5x4 instance (B).
module tb_laplacian_window_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic       a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic       a_out_last, a_busy, a_frame_done;
  logic [7:0] a_in_pixel;
  logic [7:0] a_p [1:9];

  logic       b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic       b_out_last, b_busy, b_frame_done;
  logic [7:0] b_in_pixel;
  logic [7:0] b_p [1:9];

  laplacian_window_ctrl #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pixel(a_in_pixel),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .p1(a_p[1]), .p2(a_p[2]), .p3(a_p[3]), .p4(a_p[4]), .p5(a_p[5]),
    .p6(a_p[6]), .p7(a_p[7]), .p8(a_p[8]), .p9(a_p[9]),
    .out_last(a_out_last), .busy(a_busy), .frame_done(a_frame_done)
  );

  laplacian_window_ctrl #(.IMG_W(5), .IMG_H(4), .PIX_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pixel(b_in_pixel),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .p1(b_p[1]), .p2(b_p[2]), .p3(b_p[3]), .p4(b_p[4]), .p5(b_p[5]),
    .p6(b_p[6]), .p7(b_p[7]), .p8(b_p[8]), .p9(b_p[9]),
    .out_last(b_out_last), .busy(b_busy), .frame_done(b_frame_done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  logic [71:0] qa [$];
  logic        qla [$];
  int          fd_a = 0, fd_cyc_a = 0, acc_cyc_a = 0;
  logic [71:0] qb [$];
  logic        qlb [$];
  int          fd_b = 0;

  function automatic logic [71:0] win_a();
    return {a_p[1], a_p[2], a_p[3], a_p[4], a_p[5], a_p[6], a_p[7], a_p[8], a_p[9]};
  endfunction

  function automatic logic [71:0] win_b();
    return {b_p[1], b_p[2], b_p[3], b_p[4], b_p[5], b_p[6], b_p[7], b_p[8], b_p[9]};
  endfunction

  // Reference window centred on (r,c) for pixel = r*w + c + off
  function automatic logic [71:0] exp_win(input int r, input int c, input int w, input int off);
    logic [71:0] v;
    v = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        v = {v[63:0], 8'((r + dr) * w + (c + dc) + off)};
    return v;
  endfunction

  // Capture accepted windows and frame_done pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) begin
      qa.push_back(win_a());
      qla.push_back(a_out_last);
      acc_cyc_a = cyc;
    end
    if (a_frame_done) begin
      fd_a++;
      fd_cyc_a = cyc;
    end
    if (b_out_valid && b_out_ready) begin
      qb.push_back(win_b());
      qlb.push_back(b_out_last);
    end
    if (b_frame_done) fd_b++;
  end

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] pix);
    bit ok;
    ok = 1'b0;
    a_in_valid = 1'b1;
    a_in_pixel = pix;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("a_in_ready_wait", 72'(ok), 72'(1));
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] pix);
    bit ok;
    ok = 1'b0;
    b_in_valid = 1'b1;
    b_in_pixel = pix;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("b_in_ready_wait", 72'(ok), 72'(1));
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic pulse_start_a();
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic run_frame_a(input int off);
    pulse_start_a();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        send_a(8'(r * 4 + c + off));
  endtask

  task automatic wait_done_a();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("a_frame_done_seen", 72'(ok), 72'(1));
    @(posedge clk); #1;
  endtask

  task automatic check_frame_a(input string tag, input int off);
    chk($sformatf("%s_count", tag), 72'(qa.size()), 72'(4));
    for (int i = 0; i < qa.size() && i < 4; i++) begin
      chk($sformatf("%s_win%0d", tag, i), qa[i], exp_win(1 + i / 2, 1 + i % 2, 4, off));
      chk($sformatf("%s_last%0d", tag, i), 72'(qla[i]), 72'(i == 3));
    end
    chk($sformatf("%s_done_cnt", tag), 72'(fd_a), 72'(1));
    chk($sformatf("%s_done_lat", tag), 72'(fd_cyc_a - acc_cyc_a), 72'(1));
    chk($sformatf("%s_busy_end", tag), 72'(a_busy), 72'(0));
    qa.delete();
    qla.delete();
    fd_a = 0;
  endtask

  initial begin
    rst = 1'b1;
    a_start = 0; a_in_valid = 0; a_in_pixel = '0; a_out_ready = 1'b1;
    b_start = 0; b_in_valid = 0; b_in_pixel = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 72'(a_busy), 72'(0));
    chk("rst_out_valid", 72'(a_out_valid), 72'(0));
    chk("rst_in_ready", 72'(a_in_ready), 72'(0));
    chk("rst_out_last", 72'(a_out_last), 72'(0));
    chk("rst_frame_done", 72'(a_frame_done), 72'(0));
    chk("rst_window", win_a(), 72'(0));
    chk("rst_b_out_valid", 72'(b_out_valid), 72'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", 72'(a_in_ready), 72'(0));

    // Basic 4x4 frame, full throughput
    run_frame_a(0);
    wait_done_a();
    check_frame_a("basic", 0);
    chk("basic_first_explicit", exp_win(1, 1, 4, 0), 72'h00_01_02_04_05_06_08_09_0a);

    // Backpressure right after the first window
    pulse_start_a();
    for (int k = 0; k <= 10; k++) send_a(8'(k));
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_in_pixel = 8'd11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_in_ready%0d", i), 72'(a_in_ready), 72'(0));
      chk($sformatf("bp_out_valid%0d", i), 72'(a_out_valid), 72'(1));
      chk($sformatf("bp_window%0d", i), win_a(), 72'h00_01_02_04_05_06_08_09_0a);
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    for (int k = 11; k <= 15; k++) send_a(8'(k));
    wait_done_a();
    check_frame_a("bp", 0);

    // start pulses mid-frame and during flush are ignored
    pulse_start_a();
    for (int k = 0; k <= 6; k++) send_a(8'(k));
    pulse_start_a();
    chk("sib_busy", 72'(a_busy), 72'(1));
    for (int k = 7; k <= 15; k++) send_a(8'(k));
    pulse_start_a();
    wait_done_a();
    check_frame_a("sib", 0);
    @(posedge clk); #1;
    chk("sib_idle_after", 72'(a_busy), 72'(0));

    // Input gaps on the 5x4 instance
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        send_b(8'(r * 5 + c));
      end
    repeat (4) @(posedge clk);
    #1;
    chk("gap_count", 72'(qb.size()), 72'(6));
    for (int i = 0; i < qb.size() && i < 6; i++) begin
      chk($sformatf("gap_win%0d", i), qb[i], exp_win(1 + i / 3, 1 + i % 3, 5, 0));
      chk($sformatf("gap_last%0d", i), 72'(qlb[i]), 72'(i == 5));
    end
    chk("gap_done_cnt", 72'(fd_b), 72'(1));

    // Reset after 7 pixels aborts the frame
    pulse_start_a();
    for (int k = 0; k <= 6; k++) send_a(8'(k));
    rst = 1'b1;
    #1;
    chk("mrst_busy", 72'(a_busy), 72'(0));
    chk("mrst_out_valid", 72'(a_out_valid), 72'(0));
    chk("mrst_in_ready", 72'(a_in_ready), 72'(0));
    chk("mrst_window", win_a(), 72'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_no_done", 72'(fd_a), 72'(0));
    chk("mrst_no_windows", 72'(qa.size()), 72'(0));
    run_frame_a(0);
    wait_done_a();
    check_frame_a("mrst", 0);

    // Back-to-back frames; second frame uses shifted pixel values
    run_frame_a(0);
    wait_done_a();
    check_frame_a("b2b1", 0);
    run_frame_a(100);
    wait_done_a();
    check_frame_a("b2b2", 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/laplacian_window_ctrl.md
Name: laplacian_window_ctrl

Overview:
- Streaming front-end that sequences the 3x3 Laplacian kernel datapath over a raster-scan frame.
- Accepts one pixel per handshake, keeps two line buffers and a 3x3 window register, and emits one registered window per interior pixel.
- Its p1..p9 outputs feed the combinational Laplacian kernel directly.
- Tracks frame position, flags the last window, and applies backpressure when the consumer stalls.

Parameters:
- IMG_W, 64, frame width in pixels (>=3)
- IMG_H, 64, frame height in pixels (>=3)
- PIX_W, 8, pixel width in bits

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; arms a new frame when idle
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel
- in_pixel  in  PIX_W  raster-order pixel
- out_valid  out  1  window outputs hold a valid window
- out_ready  in  1  downstream accepts the window
- p1..p9  out  PIX_W each  window, row-major from top-left; p5 is the centre
- out_last  out  1  qualifies the final window of the frame
- busy  out  1  frame in progress (any state except IDLE)
- frame_done  out  1  one-cycle pulse after the last window is accepted

Behaviour:
- Reset: all outputs 0, FSM in IDLE, row/col counters 0. Line buffer contents are don't-care.
- Reset asserted mid-frame aborts the frame: no frame_done, and out_valid drops immediately.
- FSM:
  - IDLE -> ACTIVE on start. In IDLE, in_ready=0.
  - ACTIVE: accept pixels. Input accept = in_valid & in_ready.
  - ACTIVE -> FLUSH on accepting pixel (IMG_H-1, IMG_W-1).
  - FLUSH: in_ready=0; wait until the last window is accepted (out_valid & out_ready & out_last).
  - FLUSH -> IDLE on that acceptance, with frame_done=1 for that one cycle.
- start outside IDLE is ignored.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1, each $clog2 wide.
  - col wraps to 0 and row increments on accepting col=IMG_W-1.
- Line buffers:
  - lb0 holds row r-1 and lb1 holds row r-2, each addressed by col.
  - On accept at col c, read lb0[c] and lb1[c], write lb1[c]<=lb0[c] and lb0[c]<=in_pixel in the same cycle.
  - Reads return the old data (read-before-write).
- Window:
  - On each accept, the 3x3 shift register shifts left one column.
  - The new right column is top=lb1[c], mid=lb0[c], bottom=in_pixel.
  - Shifting happens on every accept, including rows 0-1 and cols 0-1; those windows are simply never emitted.
- Emission:
  - After an accept at (r,c) with r>=2 and c>=2, the next cycle presents out_valid=1 with the window centred on (r-1,c-1).
  - Latency is one cycle from input accept to out_valid.
  - out_last=1 when r=IMG_H-1 and c=IMG_W-1.
  - Each frame emits exactly (IMG_W-2)*(IMG_H-2) windows. No border padding.
- Output register:
  - Holds stable while out_valid & !out_ready.
  - Clears out_valid on acceptance unless a new window loads in the same cycle.
- Backpressure: in_ready = (state==ACTIVE) & (!out_valid | out_ready).
  - Gives full throughput with no combinational path from in_valid to out_valid.
  - Simultaneous accept and emit in one cycle is legal and loses no window.
- Row wrap: windows never span rows. Cols 0-1 of each row are accepted without emission.
- Arithmetic is positional only; no pixel arithmetic in this block.

Decomposition:
- Package laplacian_pkg:
  - FSM state typedef: IDLE, ACTIVE, FLUSH.
  - Window index constants: P_TL..P_BR, with P_C = 4 for the centre.
  - Default IMG_W/IMG_H/PIX_W constants.
- Sub-module lap_line_buffer: single-port, read-before-write, depth IMG_W, width PIX_W, synchronous write and combinational read.
  - Instantiated twice for lb0 and lb1.
- Counters, FSM and window registers stay in the top module.

Test Plan:
- Basic frame: IMG_W=4, IMG_H=4, pixel=r*4+c, out_ready=1.
  - Exactly 4 windows, in order.
  - First window p1..p9 = 0,1,2,4,5,6,8,9,10.
  - Last window = 5,6,7,9,10,11,13,14,15 with out_last=1.
  - frame_done pulses one cycle after the last window is accepted.
- Backpressure: hold out_ready=0 for 5 cycles after the first out_valid.
  - in_ready=0 throughout; window stays stable at 0,1,2,4,5,6,8,9,10.
  - On release, the remaining 3 windows arrive with no loss and no duplication.
- Input gaps: random in_valid gaps on a 5x4 frame.
  - Window sequence is identical to the gap-free run: 6 windows, centres (1,1),(1,2),(1,3),(2,1),(2,2),(2,3).
- start while busy: pulse start mid-frame.
  - No effect; counters and outputs continue; one frame_done only.
- Reset mid-frame: assert rst after 7 pixels.
  - All outputs 0 and busy=0 immediately.
  - After start, a fresh 4x4 frame reproduces the scenario 1 results exactly.
- Back-to-back frames: start in the cycle after frame_done.
  - Second frame output matches the first; no stale line-buffer data appears in any emitted window.
